prog_load_rx: RTL and testbench
===============================

# prog_load_rx

Receiver half of the MEST-Pro program-transfer link. It deserializes a framed bit stream from the board-side program transmitter, checks per-word parity, the word count and the checksum, and writes each program word into processor instruction memory at consecutive addresses. `cpu_hold` keeps the core stalled until a load completes cleanly. It sits inside `asic_top` between the transfer link and the instruction-memory write port.

## Interface
- `DEPTH`, 256: instruction-memory depth in words; the maximum legal word count.
- `ADDR_W`, 8: memory address width; must satisfy 2^ADDR_W >= DEPTH.
- `TIMEOUT`, 1024: maximum clk cycles allowed between bit strobes while a frame is in progress.

Ports:
- `clk`  in  1  system clock; one clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  single-cycle pulse that arms the receiver (from the debounced BTN[1]).
- `ser_valid`  in  1  single-cycle strobe; one per bit.
- `ser_data`  in  1  bit value, sampled only when `ser_valid` = 1.
- `mem_we`  out  1  instruction-memory write enable; one-cycle pulse per word.
- `mem_addr`  out  ADDR_W  write address.
- `mem_wdata`  out  16  write data.
- `busy`  out  1  high while armed and receiving.
- `done`  out  1  sticky; the load completed and the checksum matched.
- `err`  out  1  sticky; the load failed.
- `cpu_hold`  out  1  holds the processor stalled; released only by `done`.

## Operation
- **Frame format:** 18 bits per frame. Start bit is 1. Then 16 data bits, MSB first. Then one even-parity bit covering the 16 data bits.
- **Transfer sequence:** header word N (1..DEPTH), then N data words, then a checksum word. The checksum is the sum of the data words mod 2^16.
- **Idle line:** while a frame is not in progress, strobes carrying 0 are ignored. A strobe carrying 1 is the start bit.
- **State machine:** IDLE, HDR, DATA, CSUM, DONE, ERROR.
  - IDLE → HDR on `start`.
  - HDR → DATA when a valid header arrives with 1 <= N <= DEPTH.
  - HDR → ERROR when N = 0 or N > DEPTH.
  - DATA → CSUM after the Nth data word.
  - CSUM → DONE if the checksum matches, otherwise → ERROR.
  - Any receiving state → ERROR on a parity error, or when TIMEOUT cycles pass without a strobe mid-frame.
  - DONE or ERROR → HDR on `start`. Re-arming clears `done` and `err`, zeroes the address counter and the checksum, and sets `cpu_hold`.
- **Ignored events:**
  - `start` while in HDR, DATA or CSUM.
  - Strobes in IDLE, DONE or ERROR.
- **Memory writes:** the data word at index k is written to `mem_addr` = k, for k = 0..N-1. The header and the checksum are never written.
- **Word count:** a 9-bit word counter compares against N, so DEPTH = 256 is legal.
- **Simultaneous events:** if `start` and `ser_valid` arrive in the same cycle in IDLE, the strobe is ignored and the first frame bit is the next strobe.
- **Reset values:** `mem_we` = 0, `mem_addr` = 0, `mem_wdata` = 0, `busy` = 0, `done` = 0, `err` = 0, `cpu_hold` = 1, state = IDLE.
- **Reset mid-transfer:** returns the block to the reset values immediately, and already-written memory is not cleared.

## Timing
- `busy` rises the cycle after `start` and falls the cycle DONE or ERROR is entered.
- For data frames, `mem_we` pulses for exactly one cycle, the cycle after the parity-bit strobe. `mem_addr` and `mem_wdata` are valid in that same cycle.
- `done` and `err` assert the cycle after the final parity strobe or the failing strobe.
- A timeout error asserts on cycle TIMEOUT+1 after the last strobe.
- `cpu_hold` falls in the same cycle `done` rises.
- Strobes may be back-to-back, one per cycle. The minimum load time is 18·(N+2) cycles plus 1.

## Structure
- **Shared package `prog_load_pkg`:**
  - state enum `pl_state_t`;
  - `WORD_W` = 16;
  - `FRAME_BITS` = 18;
  - `START_BIT` = 1'b1.
- **Sub-module `prog_word_deser`:** handles the per-frame work.
  - start detect, shift register, 5-bit bit counter, parity check and watchdog counter;
  - outputs are `word_valid`, `word`, `parity_err` and `timeout`;
  - it has its own `abort` input, driven by the parent on re-arm and reset.
- **Top level (`prog_load_rx`):** the FSM, word counter, address counter and checksum accumulator.

## Test plan
- **Good 3-word load:** `start`, then N = 3, words 0x1234, 0xABCD, 0x0277, checksum 0xC078, back-to-back strobes. Expect:
  - writes (0, 0x1234), (1, 0xABCD), (2, 0x0277), each a single `mem_we` pulse;
  - `done` = 1, `err` = 0, `cpu_hold` = 0.
- **Parity error:** same load, but the second data word has its parity bit flipped. Expect:
  - exactly one write, (0, 0x1234);
  - `err` = 1, `cpu_hold` = 1, `busy` = 0.
- **Header bounds:** three separate loads.
  - N = 0 gives `err` with no writes.
  - N = 257 gives `err` with no writes.
  - N = 256 with an incrementing pattern writes addresses 0..255 and gives `done`.
- **Checksum mismatch:** N = 1, word 0x0005, checksum 0x0006. Expect one write, then `err` = 1 and `done` = 0.
- **Timeout:** stop strobes after bit 7 of a data frame. Expect `err` exactly TIMEOUT+1 cycles later. Then a new `start` plus a good load gives `done`, with `err` cleared at re-arm.
- **Reset and start-while-busy:**
  - `reset` asserted mid-DATA gives all reset values the next cycle.
  - `start` pulsed mid-transfer is ignored and the transfer completes with `done`.

Source files
------------

// File: rtl/prog_load_pkg.sv
// Shared types and constants for the program-transfer receiver.
package prog_load_pkg;
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_DATA,
        ST_CSUM,
        ST_DONE,
        ST_ERROR
    } pl_state_t;

    localparam int   WORD_W     = 16;
    localparam int   FRAME_BITS = 18;
    localparam logic START_BIT  = 1'b1;
endpackage

// File: rtl/prog_word_deser.sv
// Per-frame deserializer: start detect, 16-bit shift-in, even-parity check and
// mid-frame watchdog. Result pulses are combinational in the parity-strobe cycle.
module prog_word_deser
    import prog_load_pkg::*;
#(
    parameter int TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              abort,
    input  logic              ser_valid,
    input  logic              ser_data,
    output logic              word_valid,
    output logic [WORD_W-1:0] word,
    output logic              parity_err,
    output logic              timeout
);
    localparam int WD_W = $clog2(TIMEOUT + 1);

    logic              in_frame_q, in_frame_d;
    logic [4:0]        bit_cnt_q, bit_cnt_d;
    logic [WORD_W-1:0] shift_q, shift_d;
    logic [WD_W-1:0]   wd_q, wd_d;

    assign word = shift_q;

    always_comb begin
        in_frame_d = in_frame_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        wd_d       = wd_q;
        word_valid = 1'b0;
        parity_err = 1'b0;
        timeout    = 1'b0;
        if (abort) begin
            in_frame_d = 1'b0;
            bit_cnt_d  = '0;
            shift_d    = '0;
            wd_d       = '0;
        end else if (ser_valid) begin
            wd_d = '0;
            if (!in_frame_q) begin
                // Zero strobes on an idle line carry no information.
                if (ser_data == START_BIT) begin
                    in_frame_d = 1'b1;
                    bit_cnt_d  = 5'd1;
                end
            end else if (bit_cnt_q == 5'(FRAME_BITS - 1)) begin
                if ((^shift_q ^ ser_data) == 1'b0) word_valid = 1'b1;
                else                               parity_err = 1'b1;
                in_frame_d = 1'b0;
                bit_cnt_d  = '0;
            end else begin
                shift_d   = {shift_q[WORD_W-2:0], ser_data};
                bit_cnt_d = bit_cnt_q + 5'd1;
            end
        end else if (in_frame_q) begin
            if (wd_q == WD_W'(TIMEOUT - 1)) timeout = 1'b1;
            else                            wd_d = wd_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        in_frame_q <= in_frame_d;
        bit_cnt_q  <= bit_cnt_d;
        shift_q    <= shift_d;
        wd_q       <= wd_d;
    end
endmodule

// File: rtl/prog_load_rx.sv
// Program-load receiver: header/data/checksum sequencing, instruction-memory
// writes and CPU hold control on top of the word deserializer.
module prog_load_rx
    import prog_load_pkg::*;
#(
    parameter int DEPTH   = 256,
    parameter int ADDR_W  = 8,
    parameter int TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              ser_valid,
    input  logic              ser_data,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              cpu_hold
);
    pl_state_t         state_q, state_d;
    logic [8:0]        n_q, n_d;
    logic [8:0]        wcnt_q, wcnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       csum_q, csum_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [15:0]       mem_wdata_q, mem_wdata_d;

    logic              receiving, abort, hdr_ok;
    logic              word_valid, parity_err, timeout;
    logic [WORD_W-1:0] word;

    assign receiving = (state_q == ST_HDR) || (state_q == ST_DATA) || (state_q == ST_CSUM);
    // Holding the deserializer cleared outside receiving states makes every
    // strobe there (including one coincident with start) a no-op.
    assign abort     = reset || !receiving;
    assign hdr_ok    = (word != '0) && ({1'b0, word} <= 17'(DEPTH));

    prog_word_deser #(.TIMEOUT(TIMEOUT)) u_deser (
        .clk        (clk),
        .abort      (abort),
        .ser_valid  (ser_valid),
        .ser_data   (ser_data),
        .word_valid (word_valid),
        .word       (word),
        .parity_err (parity_err),
        .timeout    (timeout)
    );

    always_comb begin
        state_d     = state_q;
        n_d         = n_q;
        wcnt_d      = wcnt_q;
        addr_d      = addr_q;
        csum_d      = csum_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start) begin
                    state_d    = ST_HDR;
                    wcnt_d     = '0;
                    addr_d     = '0;
                    csum_d     = '0;
                    mem_addr_d = '0;
                end
            end
            ST_HDR: begin
                if (word_valid) begin
                    if (hdr_ok) begin
                        state_d = ST_DATA;
                        n_d     = word[8:0];
                        wcnt_d  = '0;
                    end else begin
                        state_d = ST_ERROR;
                    end
                end
            end
            ST_DATA: begin
                if (word_valid) begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = addr_q;
                    mem_wdata_d = word;
                    addr_d      = addr_q + 1'b1;
                    csum_d      = csum_q + word;
                    wcnt_d      = wcnt_q + 9'd1;
                    if (wcnt_q + 9'd1 == n_q) state_d = ST_CSUM;
                end
            end
            ST_CSUM: begin
                if (word_valid) state_d = (word == csum_q) ? ST_DONE : ST_ERROR;
            end
            default: state_d = ST_IDLE;
        endcase
        if (receiving && (parity_err || timeout)) state_d = ST_ERROR;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            n_q         <= '0;
            wcnt_q      <= '0;
            addr_q      <= '0;
            csum_q      <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            n_q         <= n_d;
            wcnt_q      <= wcnt_d;
            addr_q      <= addr_d;
            csum_q      <= csum_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = receiving;
    assign done      = (state_q == ST_DONE);
    assign err       = (state_q == ST_ERROR);
    assign cpu_hold  = (state_q != ST_DONE);
endmodule

// File: tb/tb_prog_load_rx.sv
// Randomized scoreboard bench for prog_load_rx: expected writes are queued by
// a transfer-level model and checked by an independent write monitor.
module tb_prog_load_rx;
    localparam int DEPTH  = 256;
    localparam int ADDR_W = 8;
    localparam int TO     = 1024;

    logic clk = 1'b0;
    logic reset, start, ser_valid, ser_data;
    logic mem_we, busy, done, err, cpu_hold;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0] mem_wdata;

    always #5 clk = ~clk;

    prog_load_rx #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .start(start), .ser_valid(ser_valid), .ser_data(ser_data),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .busy(busy), .done(done), .err(err), .cpu_hold(cpu_hold)
    );

    typedef struct { int addr; int data; } wr_t;
    wr_t  exp_q[$];
    int   pass_cnt = 0;
    int   tot_cnt  = 0;
    bit   gaps_en;
    logic [15:0] dw [0:299];

    task automatic chk(input string nm, input int act, input int exp);
        tot_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    endtask

    // Write monitor: every mem_we pulse must match the head of the scoreboard.
    logic prev_we = 1'b0;
    wr_t  mon_e;
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            chk("we_single_pulse", int'(prev_we), 0);
            chk("we_expected", int'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                chk("wr_addr", int'(mem_addr), mon_e.addr);
                chk("wr_data", int'(mem_wdata), mon_e.data);
            end
        end
        prev_we = mem_we;
    end

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic b);
        if (gaps_en && $urandom_range(0, 3) == 0) repeat ($urandom_range(1, 4)) tick();
        ser_valid = 1'b1;
        ser_data  = b;
        tick();
        ser_valid = 1'b0;
        ser_data  = 1'b0;
    endtask

    task automatic send_word(input logic [15:0] w, input bit flip, input bit mid_start);
        if (gaps_en && $urandom_range(0, 2) == 0) strobe(1'b0);
        strobe(1'b1);
        for (int i = 15; i >= 0; i--) begin
            if (mid_start && i == 8) start = 1'b1;
            strobe(w[i]);
            start = 1'b0;
        end
        strobe((^w) ^ flip);
    endtask

    task automatic arm(input bit with_strobe);
        start = 1'b1;
        if (with_strobe) begin
            ser_valid = 1'b1;
            ser_data  = 1'b1;
        end
        tick();
        start     = 1'b0;
        ser_valid = 1'b0;
        ser_data  = 1'b0;
        chk("busy_after_start", int'(busy), 1);
        chk("done_cleared", int'(done), 0);
        chk("err_cleared", int'(err), 0);
        chk("hold_at_arm", int'(cpu_hold), 1);
    endtask

    task automatic check_reset_vals();
        chk("rst_mem_we", int'(mem_we), 0);
        chk("rst_mem_addr", int'(mem_addr), 0);
        chk("rst_mem_wdata", int'(mem_wdata), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_cpu_hold", int'(cpu_hold), 1);
    endtask

    // One complete transfer. Model: a legal header leads to writes of words
    // 0..N-1 at their index, stopping before a parity-corrupted word; success
    // only if every word arrived and csum equals the 16-bit sum of the words.
    task automatic run_load(input int n, input logic [15:0] csum, input int bad_idx,
                            input bit mid_start, input bit arm_strobe);
        bit          legal = (n >= 1) && (n <= DEPTH);
        logic [15:0] sum   = 16'h0;
        bit          exp_done;
        if (legal) begin
            for (int k = 0; k < n; k++) sum += dw[k];
            for (int k = 0; k < n && k != bad_idx; k++)
                exp_q.push_back('{addr: k, data: int'(dw[k])});
        end
        exp_done = legal && (bad_idx >= n) && (csum == sum);
        arm(arm_strobe);
        send_word(16'(n), 1'b0, 1'b0);
        if (legal) begin
            for (int k = 0; k < n; k++) begin
                send_word(dw[k], k == bad_idx, mid_start && k == n / 2);
                if (k == bad_idx) break;
            end
            if (bad_idx >= n) send_word(csum, 1'b0, 1'b0);
        end
        chk("load_done", int'(done), int'(exp_done));
        chk("load_err", int'(err), int'(!exp_done));
        chk("load_cpu_hold", int'(cpu_hold), int'(!exp_done));
        chk("load_busy", int'(busy), 0);
        @(negedge clk);
        chk("writes_drained", exp_q.size(), 0);
    endtask

    initial begin
        int          n;
        logic [15:0] s;
        reset = 1'b1; start = 1'b0; ser_valid = 1'b0; ser_data = 1'b0; gaps_en = 1'b0;
        repeat (2) tick();
        check_reset_vals();
        reset = 1'b0;
        tick();

        // Good 3-word load, back-to-back, with a strobe coincident with start.
        dw[0] = 16'h1234; dw[1] = 16'hABCD; dw[2] = 16'h0277;
        run_load(3, 16'hC078, 999, 1'b0, 1'b1);
        // Parity error on the second data word.
        run_load(3, 16'hC078, 1, 1'b0, 1'b1);
        // Header bounds.
        run_load(0, 16'h0000, 999, 1'b0, 1'b0);
        run_load(257, 16'h0000, 999, 1'b0, 1'b0);
        for (int k = 0; k < 256; k++) dw[k] = 16'(k);
        run_load(256, 16'h7F80, 999, 1'b0, 1'b0);
        // Checksum mismatch.
        dw[0] = 16'h0005;
        run_load(1, 16'h0006, 999, 1'b0, 1'b0);

        // Timeout after bit 7 of the first data frame.
        dw[0] = 16'h5A5A;
        arm(1'b0);
        exp_q.push_back('{addr: 0, data: int'(dw[0])});
        send_word(16'd2, 1'b0, 1'b0);
        send_word(dw[0], 1'b0, 1'b0);
        strobe(1'b1);
        for (int i = 15; i >= 9; i--) strobe(dw[1][i]);
        for (int k = 1; k <= TO; k++) begin
            tick();
            if (k == TO - 1) chk("timeout_not_early", int'(err), 0);
            if (k == TO) begin
                chk("timeout_err", int'(err), 1);
                chk("timeout_busy", int'(busy), 0);
            end
        end
        @(negedge clk);
        chk("timeout_writes", exp_q.size(), 0);

        gaps_en = 1'b1;
        for (int k = 0; k < 4; k++) dw[k] = 16'($urandom);
        s = dw[0] + dw[1] + dw[2] + dw[3];
        run_load(4, s, 999, 1'b0, 1'b0);

        // Reset in the middle of DATA.
        gaps_en = 1'b0;
        dw[0] = 16'hBEEF;
        arm(1'b0);
        exp_q.push_back('{addr: 0, data: int'(dw[0])});
        send_word(16'd3, 1'b0, 1'b0);
        send_word(dw[0], 1'b0, 1'b0);
        repeat (5) strobe(1'b1);
        reset = 1'b1;
        tick();
        check_reset_vals();
        reset = 1'b0;
        @(negedge clk);
        chk("reset_writes", exp_q.size(), 0);

        // Start pulsed mid-transfer is ignored.
        gaps_en = 1'b1;
        for (int k = 0; k < 6; k++) dw[k] = 16'($urandom);
        s = 16'h0;
        for (int k = 0; k < 6; k++) s += dw[k];
        run_load(6, s, 999, 1'b1, 1'b0);

        // Random loads: good, bad checksum or a random parity fault.
        for (int t = 0; t < 6; t++) begin
            n = $urandom_range(1, 12);
            s = 16'h0;
            for (int k = 0; k < n; k++) begin
                dw[k] = 16'($urandom);
                s += dw[k];
            end
            case ($urandom_range(0, 2))
                0: run_load(n, s, 999, 1'b0, 1'($urandom_range(0, 1)));
                1: run_load(n, s ^ 16'(1 << $urandom_range(0, 15)), 999, 1'b0, 1'b0);
                default: run_load(n, s, $urandom_range(0, n - 1), 1'b0, 1'b0);
            endcase
        end

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end
endmodule
